// File: rtl/mpeg_ctrl_pkg.sv
// Shared definitions for the MPEG DCT/IDCT control FSMs: state encoding and block geometry.
package mpeg_ctrl_pkg;

    localparam int BLK_N          = 8;
    localparam int BLK_SZ         = 64;
    localparam int ACCUM_LEN      = 63;
    localparam int CYCLES_PER_PIX = 67;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        PREF,
        ACCUM,
        DRAIN,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/idx_counter2d.sv
// Two-dimensional wrapping index counter: lo is the fast index, hi advances when lo wraps.
module idx_counter2d #(
    parameter int COORD_W = 3
) (
    input  logic                   clk,
    input  logic                   rst_in,
    input  logic                   inc,
    input  logic                   clr,
    output logic [COORD_W-1:0]     lo,
    output logic [COORD_W-1:0]     hi,
    output logic [2*COORD_W-1:0]   flat,
    output logic                   last
);

    localparam logic [2*COORD_W-1:0] ONE = 1;

    logic [2*COORD_W-1:0] count;

    // A single flat count gives the lo->hi carry and the full wrap for free.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + ONE;
        end
    end

    assign flat = count;
    assign lo   = count[COORD_W-1:0];
    assign hi   = count[2*COORD_W-1:COORD_W];
    assign last = &count;

endmodule

// File: rtl/idct_fsm_control.sv
// Inverse-DCT control FSM: for every output pixel, streams all 64 coefficients into the MAC,
// then writes the pixel back; pulses ready when the whole 8x8 block is done.
module idct_fsm_control
    import mpeg_ctrl_pkg::*;
#(
    parameter int COORD_W = 3,
    parameter int ADDR_W  = 6
) (
    input  logic               clk,
    input  logic               rst_in,
    input  logic               start,
    output logic               ready,
    output logic               busy,
    output logic [COORD_W-1:0] u,
    output logic [COORD_W-1:0] v,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [ADDR_W-1:0]  address,
    output logic [ADDR_W-1:0]  pix_addr,
    output logic               rd_en,
    output logic               act_mac,
    output logic               rst_out,
    output logic               wr_en
);

    state_t state;
    state_t next_state;

    logic rd_en_d, act_mac_d, rst_out_d, wr_en_d, ready_d, busy_d;
    logic uv_inc, uv_clr, uv_last;
    logic xy_inc, xy_last;

    idx_counter2d #(.COORD_W(COORD_W)) uv_cnt (
        .clk  (clk),
        .rst_in(rst_in),
        .inc  (uv_inc),
        .clr  (uv_clr),
        .lo   (u),
        .hi   (v),
        .flat (address),
        .last (uv_last)
    );

    idx_counter2d #(.COORD_W(COORD_W)) xy_cnt (
        .clk  (clk),
        .rst_in(rst_in),
        .inc  (xy_inc),
        .clr  (1'b0),
        .lo   (x),
        .hi   (y),
        .flat (pix_addr),
        .last (xy_last)
    );

    // Strobes are decoded from next_state and registered so every output comes straight off a flop.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state   <= IDLE;
            rd_en   <= 1'b0;
            act_mac <= 1'b0;
            rst_out <= 1'b1;
            wr_en   <= 1'b0;
            ready   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= next_state;
            rd_en   <= rd_en_d;
            act_mac <= act_mac_d;
            rst_out <= rst_out_d;
            wr_en   <= wr_en_d;
            ready   <= ready_d;
            busy    <= busy_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = CLEAR;
            CLEAR:   next_state = PREF;
            PREF:    next_state = ACCUM;
            ACCUM:   if (uv_last) next_state = DRAIN;
            DRAIN:   next_state = WRITE;
            WRITE:   next_state = xy_last ? DONE : CLEAR;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The x/y wrap out of the last WRITE doubles as the return to pixel 0 for the next block.
    always_comb begin
        rd_en_d   = (next_state == PREF) || (next_state == ACCUM);
        act_mac_d = (next_state == ACCUM) || (next_state == DRAIN);
        rst_out_d = (next_state != CLEAR);
        wr_en_d   = (next_state == WRITE);
        ready_d   = (next_state == DONE);
        busy_d    = (next_state != IDLE);
        uv_inc    = (next_state == ACCUM);
        uv_clr    = (next_state == CLEAR) || (next_state == DONE);
        xy_inc    = (state == WRITE);
    end

endmodule

// File: doc/idct_fsm_control.md
Name: idct_fsm_control

Overview:
- Control FSM for the inverse-DCT datapath of the MPEG block, the decode-side counterpart of the forward-DCT control FSM.
- For each of the 64 output pixels (x,y) of an 8x8 block, it sequences all 64 coefficients (u,v) through coefficient memory into the shared MAC.
- It then writes back the accumulated pixel and pulses ready at block end.
- Keeps the same rd_en / act_mac / rst_out contract the MAC and memories already use.

Parameters:
- COORD_W, 3, width of each index u, v, x, y (block side 2^COORD_W = 8).
- ADDR_W, 6, coefficient/pixel address width (2*COORD_W).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_in  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to process one block; sampled only in IDLE.
- ready  out  1  one-cycle pulse: block finished.
- busy  out  1  high from the cycle after start is accepted until the ready cycle, inclusive.
- u, v  out  COORD_W each  current coefficient indices (frequency).
- x, y  out  COORD_W each  current output pixel indices (spatial).
- address  out  ADDR_W  coefficient memory read address = {v,u}.
- pix_addr  out  ADDR_W  pixel write address = {y,x}.
- rd_en  out  1  coefficient/cosine memory read enable.
- act_mac  out  1  MAC accumulate enable.
- rst_out  out  1  active-low MAC accumulator clear.
- wr_en  out  1  pixel memory write strobe.

Behaviour:
- Reset (rst_in=0, asynchronous, any state): state=IDLE.
  - u, v, x, y, address, pix_addr = 0.
  - rd_en, act_mac, wr_en, ready, busy = 0.
  - rst_out = 1.
- States: IDLE, CLEAR, PREF, ACCUM, DRAIN, WRITE, DONE.
- IDLE -> CLEAR when start=1. All other start values are ignored; start asserted in any other state has no effect.
- CLEAR (1 cycle): rst_out=0, u=v=0, address=0. -> PREF.
- PREF (1 cycle): rd_en=1, address=0, act_mac=0. -> ACCUM.
- ACCUM (63 cycles):
  - rd_en=1, act_mac=1.
  - {v,u} increments by 1 each cycle, so address runs 1..63. u wraps 7->0 with v+1.
  - Leaves when address=63 has been issued. -> DRAIN.
- DRAIN (1 cycle): rd_en=0, act_mac=1, address holds 63. -> WRITE.
- Net handshake:
  - rd_en rises exactly 1 cycle before act_mac.
  - rd_en falls exactly 1 cycle before act_mac falls.
  - Each is high exactly 64 cycles per pixel.
- WRITE (1 cycle): wr_en=1, pix_addr={y,x}, act_mac=0.
  - Then {y,x} increments, x wrapping 7->0 with y+1.
  - If {y,x} was 63 -> DONE, else -> CLEAR.
- DONE (1 cycle): ready=1, x=y=0 and u=v=0 restored. -> IDLE.
- Only one of u/v/x/y changes per step sequence: consecutive values always differ by +1 or wrap 7->0. No skips or repeats.
- Timing:
  - 67 cycles per pixel; 64*67 = 4288 cycles from the CLEAR entry to the last WRITE.
  - ready is asserted in cycle 4289 after start is accepted.
- Index hold: u, v, x, y hold their values outside the states that step them.
- Glitches: all outputs are registered, no combinational glitches.
- Back-to-back blocks: start in the cycle after ready is accepted, giving an immediate new block.

Decomposition:
- Shared package mpeg_ctrl_pkg:
  - state enum (IDLE..DONE).
  - BLK_N=8, BLK_SZ=64.
  - ACCUM_LEN=63.
  - CYCLES_PER_PIX=67.
- One sub-module, idx_counter2d: a COORD_W x2 wrapping counter with inc, clr, outputs lo/hi/flat and a last flag.
  - Instantiated twice: (u,v) and (x,y).

Test Plan:
- Reset then a single start pulse:
  - rst_out=0 at u=v=0, address=0.
  - rd_en up 1 cycle before act_mac; rd_en down 1 cycle before act_mac down.
  - ready pulses at cycle 4289 with pix_addr=63 on the final wr_en.
- Sequence checker on every change of u, v, x, y, address, pix_addr: +1 or 7->0 / 63->0 only. Exactly 64 wr_en pulses, pix_addr 0..63 in order.
- start held high for 10 cycles mid-block: ignored, the block still finishes at 4289 with a single ready.
- rst_in=0 asserted at pixel 20, ACCUM address 30:
  - all outputs return to reset values immediately (rst_out=1).
  - a subsequent start restarts from x=y=0.
- Two blocks back-to-back (start the cycle after ready): the second ready comes 4289 cycles after the second start, with no overlap of rd_en/act_mac across blocks.
- Idle check: no start for 500 cycles -> busy, rd_en, act_mac, wr_en, ready all 0 and every index stays 0.
